// File: rtl/fb_pkg.sv
// Shared framebuffer write definitions: default sizes, write source tags and
// the scheduler state encoding.
package fb_pkg;
  localparam int FB_ADDR_W    = 17;
  localparam int FB_GUARD     = 4;
  localparam int FB_CPU_BURST = 8;

  localparam logic SRC_CPU  = 1'b0;
  localparam logic SRC_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_POP = 2'd1,
    HOLD    = 2'd2
  } sched_state_t;
endpackage

// File: rtl/sram_write_scheduler_if.sv
// Valid/ready write stream from the scheduler toward the SRAM arbiter.
interface sram_write_scheduler_if import fb_pkg::*; #(
  parameter int ADDR_W = FB_ADDR_W
) ();
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_src;

  modport master (output wr_valid, output wr_addr, output wr_data, output wr_src,
                  input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, input wr_src,
                  output wr_ready);
endinterface

// File: rtl/fill_engine.sv
// Block-fill engine: holds pointer/count/value for one fill and reports
// busy/done; the scheduler core acknowledges each accepted fill write.
module fill_engine import fb_pkg::*; #(
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk100,
  input  logic              reset,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [ADDR_W:0]   fill_len,
  input  logic [7:0]        fill_value,
  input  logic              fill_accept,
  output logic              fill_req,
  output logic [ADDR_W-1:0] fill_ptr,
  output logic [7:0]        fill_val,
  output logic              fill_busy,
  output logic              fill_done
);
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W:0]   cnt_r;
  logic [7:0]        val_r;
  logic              busy_r;
  logic              zero_done_r;
  logic              last_s;
  logic              start_ok_s;

  // Completion is flagged in the accept cycle itself; a start that collides
  // with any done pulse is dropped.
  always_comb begin
    last_s     = busy_r && fill_accept && (cnt_r == CNT_ONE);
    start_ok_s = fill_start && !busy_r && !zero_done_r;
  end

  // Fill registers: latch on start, advance on each accepted write.
  always_ff @(posedge clk100) begin
    if (reset) begin
      ptr_r       <= {ADDR_W{1'b0}};
      cnt_r       <= CNT_ZERO;
      val_r       <= 8'h00;
      busy_r      <= 1'b0;
      zero_done_r <= 1'b0;
    end else begin
      zero_done_r <= 1'b0;
      if (busy_r) begin
        if (fill_accept) begin
          ptr_r <= ptr_r + PTR_ONE;
          cnt_r <= cnt_r - CNT_ONE;
          if (last_s) begin
            busy_r <= 1'b0;
          end else begin
            busy_r <= 1'b1;
          end
        end else begin
          busy_r <= 1'b1;
        end
      end else if (start_ok_s) begin
        ptr_r       <= fill_addr;
        cnt_r       <= fill_len;
        val_r       <= fill_value;
        busy_r      <= (fill_len != CNT_ZERO);
        zero_done_r <= (fill_len == CNT_ZERO);
      end else begin
        busy_r <= 1'b0;
      end
    end
  end

  assign fill_req  = busy_r;
  assign fill_ptr  = ptr_r;
  assign fill_val  = val_r;
  assign fill_busy = busy_r && !last_s;
  assign fill_done = zero_done_r || last_s;
endmodule

// File: rtl/sram_write_scheduler.sv
// Schedules CPU FIFO writes and block-fill writes onto one valid/ready stream,
// issuing only inside the blanking window and alternating fairly under load.
module sram_write_scheduler import fb_pkg::*; #(
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int GUARD     = FB_GUARD,
  parameter int CPU_BURST = FB_CPU_BURST
) (
  input  logic                   clk100,
  input  logic                   reset,
  input  logic                   blank,
  input  logic [11:0]            blank_left,
  input  logic                   cpu_fifo_empty,
  output logic                   cpu_fifo_rd_en,
  input  logic [ADDR_W-1:0]      cpu_wr_addr,
  input  logic [7:0]             cpu_wr_data,
  input  logic                   fill_start,
  input  logic [ADDR_W-1:0]      fill_addr,
  input  logic [ADDR_W:0]        fill_len,
  input  logic [7:0]             fill_value,
  output logic                   fill_busy,
  output logic                   fill_done,
  sram_write_scheduler_if.master wr
);
  localparam int                  STREAK_W   = $clog2(CPU_BURST + 1);
  localparam logic [STREAK_W-1:0] BURST_MAX  = STREAK_W'(CPU_BURST);
  localparam logic [STREAK_W-1:0] STREAK_ONE = {{(STREAK_W-1){1'b0}}, 1'b1};
  localparam logic [11:0]         GUARD_LEFT = 12'(GUARD);

  sched_state_t      state_r, state_s;
  logic [STREAK_W-1:0] streak_r;
  logic              wr_valid_r, wr_src_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [7:0]        wr_data_r;
  logic              win_s, accept_s, cpu_grant_s, fill_grant_s, fill_accept_s;
  logic              fill_req_s;
  logic [ADDR_W-1:0] fill_ptr_s;
  logic [7:0]        fill_val_s;

  fill_engine #(.ADDR_W(ADDR_W)) u_fill (
    .clk100      (clk100),
    .reset       (reset),
    .fill_start  (fill_start),
    .fill_addr   (fill_addr),
    .fill_len    (fill_len),
    .fill_value  (fill_value),
    .fill_accept (fill_accept_s),
    .fill_req    (fill_req_s),
    .fill_ptr    (fill_ptr_s),
    .fill_val    (fill_val_s),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done)
  );

  // Next state and grants; the CPU yields only after a full burst while a fill waits.
  always_comb begin
    state_s       = state_r;
    cpu_grant_s   = 1'b0;
    fill_grant_s  = 1'b0;
    win_s         = blank && (blank_left >= GUARD_LEFT);
    accept_s      = (state_r == HOLD) && wr_valid_r && wr.wr_ready;
    fill_accept_s = accept_s && (wr_src_r == SRC_FILL);
    case (state_r)
      IDLE: begin
        if (win_s && !cpu_fifo_empty && (!fill_req_s || (streak_r != BURST_MAX))) begin
          cpu_grant_s = 1'b1;
          state_s     = CPU_POP;
        end else if (win_s && fill_req_s) begin
          fill_grant_s = 1'b1;
          state_s      = HOLD;
        end else begin
          state_s = IDLE;
        end
      end
      CPU_POP: state_s = HOLD;
      HOLD: begin
        if (accept_s) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk100) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // CPU streak counter, only meaningful while a fill is pending.
  always_ff @(posedge clk100) begin
    if (reset || !fill_req_s || fill_grant_s) begin
      streak_r <= {STREAK_W{1'b0}};
    end else if (cpu_grant_s && (streak_r != BURST_MAX)) begin
      streak_r <= streak_r + STREAK_ONE;
    end else begin
      streak_r <= streak_r;
    end
  end

  // Write stream registers: loaded on issue and frozen until the arbiter accepts.
  always_ff @(posedge clk100) begin
    if (reset) begin
      wr_valid_r <= 1'b0;
      wr_addr_r  <= {ADDR_W{1'b0}};
      wr_data_r  <= 8'h00;
      wr_src_r   <= SRC_CPU;
    end else if (fill_grant_s) begin
      wr_valid_r <= 1'b1;
      wr_addr_r  <= fill_ptr_s;
      wr_data_r  <= fill_val_s;
      wr_src_r   <= SRC_FILL;
    end else if (state_r == CPU_POP) begin
      wr_valid_r <= 1'b1;
      wr_addr_r  <= cpu_wr_addr;
      wr_data_r  <= cpu_wr_data;
      wr_src_r   <= SRC_CPU;
    end else if (accept_s) begin
      wr_valid_r <= 1'b0;
    end else begin
      wr_valid_r <= wr_valid_r;
    end
  end

  assign cpu_fifo_rd_en = cpu_grant_s;
  assign wr.wr_valid    = wr_valid_r;
  assign wr.wr_addr     = wr_addr_r;
  assign wr.wr_data     = wr_data_r;
  assign wr.wr_src      = wr_src_r;
endmodule

// File: tb/tb_sram_write_scheduler.sv
// Directed bench for sram_write_scheduler: FIFO model, scoreboard of expected
// writes popped on every accepted write, and directed edge-case checks.
module tb_sram_write_scheduler;
  import fb_pkg::*;
  localparam int AW = 17;

  typedef struct packed {
    logic          done;
    logic          src;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  logic          clk100 = 1'b0;
  logic          reset, blank, cpu_fifo_empty, cpu_fifo_rd_en;
  logic [11:0]   blank_left;
  logic [AW-1:0] cpu_wr_addr, fill_addr;
  logic [7:0]    cpu_wr_data, fill_value;
  logic [AW:0]   fill_len;
  logic          fill_start, fill_busy, fill_done;

  sram_write_scheduler_if #(.ADDR_W(AW)) wr_if ();

  sram_write_scheduler dut (
    .clk100         (clk100),
    .reset          (reset),
    .blank          (blank),
    .blank_left     (blank_left),
    .cpu_fifo_empty (cpu_fifo_empty),
    .cpu_fifo_rd_en (cpu_fifo_rd_en),
    .cpu_wr_addr    (cpu_wr_addr),
    .cpu_wr_data    (cpu_wr_data),
    .fill_start     (fill_start),
    .fill_addr      (fill_addr),
    .fill_len       (fill_len),
    .fill_value     (fill_value),
    .fill_busy      (fill_busy),
    .fill_done      (fill_done),
    .wr             (wr_if)
  );

  always #5 clk100 = ~clk100;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];
  logic [AW+7:0] fifo_mem [0:511];
  int push_cnt = 0;
  int pop_cnt = 0;
  int cyc_n = 0, done_cnt = 0, rd_seen = 0, rd_gap = 0, last_rd = 0, done0 = 0;

  assign cpu_fifo_empty = (push_cnt == pop_cnt);

  // Non-show-ahead FIFO: popped data appears the cycle after rd_en.
  always @(posedge clk100) begin
    if (cpu_fifo_rd_en && (push_cnt != pop_cnt)) begin
      {cpu_wr_addr, cpu_wr_data} <= fifo_mem[pop_cnt];
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic fifo_push(input logic [AW-1:0] a, input logic [7:0] d);
    fifo_mem[push_cnt] = {a, d};
    push_cnt++;
  endtask

  task automatic exp_push(input logic done, input logic src, input logic [AW-1:0] a,
                          input logic [7:0] d);
    exp_t e;
    e.done = done; e.src = src; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_cpu(input logic [AW-1:0] a, input logic [7:0] d);
    fifo_push(a, d);
    exp_push(1'b0, SRC_CPU, a, d);
  endtask

  task automatic mon();
    exp_t e;
    cyc_n++;
    if (fill_done === 1'b1) done_cnt++;
    if (cpu_fifo_rd_en === 1'b1) begin
      rd_seen++;
      rd_gap  = cyc_n - last_rd;
      last_rd = cyc_n;
      check("rd_while_empty", 32'(cpu_fifo_empty), 32'(0));
    end
    if (wr_if.wr_valid === 1'b1 && wr_if.wr_ready === 1'b1) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_src", 32'(wr_if.wr_src), 32'(e.src));
        check("wr_addr", 32'(wr_if.wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_if.wr_data), 32'(e.data));
        check("fill_done_at_accept", 32'(fill_done), 32'(e.done));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic look();
    @(negedge clk100);
    mon();
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      look();
    end
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) cyc(1);
    check("drain_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    reset = 1'b1; blank = 1'b0; blank_left = 12'd0; fill_start = 1'b0;
    fill_addr = '0; fill_len = '0; fill_value = 8'h00; wr_if.wr_ready = 1'b0;
    cyc(3);
    check("rst_wr_valid", 32'(wr_if.wr_valid), 32'(0));
    check("rst_rd_en", 32'(cpu_fifo_rd_en), 32'(0));
    check("rst_fill_busy", 32'(fill_busy), 32'(0));
    check("rst_fill_done", 32'(fill_done), 32'(0));
    check("rst_wr_addr", 32'(wr_if.wr_addr), 32'(0));
    check("rst_wr_data", 32'(wr_if.wr_data), 32'(0));
    check("rst_wr_src", 32'(wr_if.wr_src), 32'(0));
    tick(); reset = 1'b0; look();

    // CPU only: two entries, pops three cycles apart
    tick();
    blank = 1'b1; blank_left = 12'd100; wr_if.wr_ready = 1'b1; rd_seen = 0;
    push_cpu(17'h00010, 8'hAB); push_cpu(17'h1FFFF, 8'hCD);
    look();
    drain(20);
    check("cpu_rd_count", 32'(rd_seen), 32'(2));
    check("cpu_rd_gap", 32'(rd_gap), 32'(3));

    // Guard: 6, 5, 4 issue; 3 and blank=0 do not
    for (int g = 6; g >= 4; g--) begin
      tick(); blank_left = 12'(g); push_cpu(17'(16'h0300 + g), 8'(g)); look();
      check($sformatf("guard_issue_%0d", g), 32'(cpu_fifo_rd_en), 32'(1));
      drain(10);
    end
    tick(); blank_left = 12'd3; rd_seen = 0; push_cpu(17'h00333, 8'h33); look();
    cyc(5);
    check("guard_3_no_rd", 32'(rd_seen), 32'(0));
    tick(); blank = 1'b0; blank_left = 12'd100; look();
    cyc(5);
    check("noblank_no_rd", 32'(rd_seen), 32'(0));
    tick(); blank = 1'b1; look();
    drain(10);

    // Fill with address wrap
    tick();
    fill_addr = 17'h1FFFE; fill_len = 18'd4; fill_value = 8'h55; fill_start = 1'b1;
    done0 = done_cnt;
    a = 17'h1FFFE;
    for (int k = 0; k < 4; k++) begin
      exp_push(k == 3, SRC_FILL, a, 8'h55);
      a = a + 17'd1;
    end
    look();
    check("fill_busy_start_cycle", 32'(fill_busy), 32'(0));
    tick(); fill_start = 1'b0; look();
    check("fill_busy_next", 32'(fill_busy), 32'(1));
    drain(20);
    cyc(2);
    check("fill_done_count", 32'(done_cnt - done0), 32'(1));
    check("fill_idle_after", 32'(fill_busy), 32'(0));

    // Fairness: 8 CPU then 1 fill, repeated
    tick();
    blank = 1'b0;
    for (int i = 0; i < 160; i++) fifo_push(17'h02000 + 17'(i), 8'(i));
    fill_addr = 17'h00100; fill_len = 18'd20; fill_value = 8'h3C; fill_start = 1'b1;
    done0 = done_cnt;
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 8; j++) exp_push(1'b0, SRC_CPU, 17'h02000 + 17'(k*8 + j), 8'(k*8 + j));
      exp_push(k == 19, SRC_FILL, 17'h00100 + 17'(k), 8'h3C);
    end
    look();
    tick(); fill_start = 1'b0; look();
    tick(); blank = 1'b1; blank_left = 12'd100; look();
    drain(1000);
    check("fair_done_count", 32'(done_cnt - done0), 32'(1));
    check("fair_fifo_empty", 32'(cpu_fifo_empty), 32'(1));

    // Backpressure across the end of blanking
    tick();
    wr_if.wr_ready = 1'b0;
    push_cpu(17'h0ABCD, 8'h77); push_cpu(17'h00002, 8'h11);
    look();
    for (int i = 0; i < 10 && wr_if.wr_valid !== 1'b1; i++) cyc(1);
    check("bp_valid_up", 32'(wr_if.wr_valid), 32'(1));
    tick(); blank = 1'b0; blank_left = 12'd0; rd_seen = 0; look();
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check("bp_hold_valid", 32'(wr_if.wr_valid), 32'(1));
      check("bp_hold_addr", 32'(wr_if.wr_addr), 32'(17'h0ABCD));
      check("bp_hold_data", 32'(wr_if.wr_data), 32'(8'h77));
    end
    check("bp_no_rd", 32'(rd_seen), 32'(0));
    tick(); blank = 1'b1; blank_left = 12'd100; wr_if.wr_ready = 1'b1; look();
    drain(20);

    // Reset in the middle of a fill
    tick();
    wr_if.wr_ready = 1'b0;
    fill_addr = 17'h00400; fill_len = 18'd10; fill_value = 8'hEE; fill_start = 1'b1;
    look();
    tick(); fill_start = 1'b0; look();
    cyc(1);
    check("mid_fill_busy", 32'(fill_busy), 32'(1));
    check("mid_fill_valid", 32'(wr_if.wr_valid), 32'(1));
    done0 = done_cnt;
    tick(); reset = 1'b1; look();
    tick(); reset = 1'b0; look();
    check("rst_mid_busy", 32'(fill_busy), 32'(0));
    check("rst_mid_valid", 32'(wr_if.wr_valid), 32'(0));
    tick(); wr_if.wr_ready = 1'b1; look();
    cyc(12);
    check("rst_mid_no_done", 32'(done_cnt - done0), 32'(0));
    check("rst_mid_idle", 32'(fill_busy), 32'(0));

    // Zero-length fill
    tick();
    fill_addr = 17'h00500; fill_len = 18'd0; fill_start = 1'b1; done0 = done_cnt;
    look();
    check("len0_done_same", 32'(fill_done), 32'(0));
    tick(); fill_start = 1'b0; look();
    check("len0_done", 32'(fill_done), 32'(1));
    check("len0_busy", 32'(fill_busy), 32'(0));
    cyc(1);
    check("len0_done_once", 32'(fill_done), 32'(0));
    check("len0_done_count", 32'(done_cnt - done0), 32'(1));
    check("len0_busy_after", 32'(fill_busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
